// File: rtl/avst_host_mux_pkg.sv
// Shared types and command-layout helpers for the host command mux.
package avst_host_mux_pkg;

    localparam int unsigned MAX_CH       = 8;
    localparam int unsigned CH_IDX_W     = 3;
    localparam int unsigned DEF_ADDR_W   = 48;
    localparam int unsigned DEF_DATA_W   = 512;

    typedef logic [CH_IDX_W-1:0] t_ch_idx;

    function automatic int unsigned cmd_w(input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int unsigned cmd_wr_bit(input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w;
    endfunction

    function automatic int unsigned cmd_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    localparam int unsigned CMD_WR_BIT   = cmd_wr_bit(DEF_ADDR_W, DEF_DATA_W);
    localparam int unsigned CMD_ADDR_LSB = cmd_addr_lsb(DEF_DATA_W);

endpackage

// File: rtl/avst_host_cmd_mux_tag_fifo.sv
// In-order register FIFO of channel indices for reads in flight; head is readable without a pop.
module avst_tag_fifo
    import avst_host_mux_pkg::*;
#(
    parameter int unsigned DEPTH = 64
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  t_ch_idx                  push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output t_ch_idx                  head
);

    localparam int unsigned AW = $clog2(DEPTH);

    t_ch_idx         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/avst_host_cmd_mux.sv
// Round-robin merge of NUM_CH Avalon-ST command streams onto one host port, with in-order
// read-response steering. Optional per-channel grant counters: AVST_HOST_CMD_MUX_STATS_EN.
module avst_host_cmd_mux
    import avst_host_mux_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned ADDR_W          = 48,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned MAX_OUTSTANDING = 64
)
(
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_CH*cmd_w(ADDR_W,DATA_W)-1:0] in_cmd_data,
    input  logic [NUM_CH-1:0]                      in_cmd_valid,
    output logic [NUM_CH-1:0]                      in_cmd_ready,
    output logic [cmd_w(ADDR_W,DATA_W)-1:0]        out_cmd_data,
    output logic                                   out_cmd_valid,
    input  logic                                   out_cmd_ready,
    input  logic [DATA_W-1:0]                      in_rsp_data,
    input  logic                                   in_rsp_valid,
    output logic                                   in_rsp_ready,
    output logic [DATA_W-1:0]                      out_rsp_data,
    output logic [NUM_CH-1:0]                      out_rsp_valid,
    input  logic [NUM_CH-1:0]                      out_rsp_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
    output logic                                   err_orphan_rsp,
    output logic [NUM_CH*32-1:0]                   grant_count
);

    localparam int unsigned CMD_W  = cmd_w(ADDR_W, DATA_W);
    localparam int unsigned WR_BIT = cmd_wr_bit(ADDR_W, DATA_W);
    localparam int unsigned OW     = $clog2(MAX_OUTSTANDING) + 1;

    logic [CMD_W-1:0]   ch_cmd [NUM_CH];
    logic [NUM_CH-1:0]  eligible;
    logic [MAX_CH-1:0]  elig_ext;
    logic [NUM_CH-1:0]  grant_oh;
    logic [CMD_W-1:0]   sel_cmd;
    t_ch_idx            rr_ptr;
    t_ch_idx            grant_idx;
    t_ch_idx            next_ptr;
    logic               grant_any;
    logic               load;
    logic               tag_push;
    logic               tag_pop;
    logic               head_ready;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OW-1:0]      fifo_count;
    t_ch_idx            fifo_head;
    logic [CMD_W-1:0]   cmd_q;
    logic               cmd_valid_q;
    logic               err_q;

    // A read may only be granted while there is room to remember where its response goes.
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        assign ch_cmd[g]   = in_cmd_data[g*CMD_W +: CMD_W];
        assign eligible[g] = in_cmd_valid[g] && (ch_cmd[g][WR_BIT] || !fifo_full);
    end

    assign elig_ext = MAX_CH'(eligible);

    // First eligible channel at or after the pointer, wrapping.
    always_comb begin
        logic [CH_IDX_W:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < int'(NUM_CH); off++) begin
            cand = {1'b0, rr_ptr} + (CH_IDX_W+1)'(off);
            if (cand >= (CH_IDX_W+1)'(NUM_CH)) begin
                cand = cand - (CH_IDX_W+1)'(NUM_CH);
            end
            if (!grant_any && elig_ext[cand[CH_IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[CH_IDX_W-1:0];
            end
        end
    end

    assign load     = grant_any && (!cmd_valid_q || out_cmd_ready);
    assign next_ptr = (grant_idx == t_ch_idx'(NUM_CH-1)) ? '0 : grant_idx + t_ch_idx'(1);

    always_comb begin
        sel_cmd    = '0;
        grant_oh   = '0;
        head_ready = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant_idx == t_ch_idx'(i)) begin
                sel_cmd     = ch_cmd[i];
                grant_oh[i] = load;
            end
            if (fifo_head == t_ch_idx'(i)) begin
                head_ready = out_rsp_ready[i];
            end
        end
    end

    assign tag_push = load && !sel_cmd[WR_BIT];
    assign tag_pop  = !fifo_empty && in_rsp_valid && head_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            rr_ptr      <= '0;
        end else if (load) begin
            cmd_q       <= sel_cmd;
            cmd_valid_q <= 1'b1;
            rr_ptr      <= next_ptr;
        end else if (out_cmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

    // A response with nothing outstanding is swallowed and flagged until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (in_rsp_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    avst_tag_fifo #(
        .DEPTH     (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tag_push),
        .push_data (grant_idx),
        .pop       (tag_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Handshake outputs are combinational; reset forces them low along with the registers.
    always_comb begin
        out_rsp_valid = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            out_rsp_valid[i] = reset_n && !fifo_empty && in_rsp_valid && (fifo_head == t_ch_idx'(i));
        end
    end

    assign in_cmd_ready   = grant_oh & {NUM_CH{reset_n}};
    assign in_rsp_ready   = reset_n && (fifo_empty ? in_rsp_valid : head_ready);
    assign out_rsp_data   = in_rsp_data & {DATA_W{reset_n}};
    assign out_cmd_data   = cmd_q;
    assign out_cmd_valid  = cmd_valid_q;
    assign outstanding    = fifo_count;
    assign err_orphan_rsp = err_q;

`ifdef AVST_HOST_CMD_MUX_STATS_EN
    logic [31:0] grant_cnt [NUM_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (grant_oh[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt
        assign grant_count[g*32 +: 32] = grant_cnt[g];
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_avst_host_cmd_mux.sv
// Self-checking bench for avst_host_cmd_mux against a queue-based behavioural model.
module tb_avst_host_cmd_mux;

    localparam int NCH  = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int CW   = DW + AW + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NCH*CW-1:0]    in_cmd_data;
    logic [NCH-1:0]       in_cmd_valid;
    logic [NCH-1:0]       in_cmd_ready;
    logic [CW-1:0]        out_cmd_data;
    logic                 out_cmd_valid;
    logic                 out_cmd_ready;
    logic [DW-1:0]        in_rsp_data;
    logic                 in_rsp_valid;
    logic                 in_rsp_ready;
    logic [DW-1:0]        out_rsp_data;
    logic [NCH-1:0]       out_rsp_valid;
    logic [NCH-1:0]       out_rsp_ready;
    logic [2:0]           outstanding;
    logic                 err_orphan_rsp;
    logic [NCH*32-1:0]    grant_count;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int            m_ptr;
    int            m_tags[$];
    logic          m_out_valid;
    logic [CW-1:0] m_out_data;
    logic          m_err;
    int            m_cnt [NCH];

    // model predictions for the current cycle
    logic [NCH-1:0] e_ready, e_rsp_valid;
    logic           e_load, e_rsp_ready, e_pop, e_orphan;
    int             e_g;

    always #5 clk = ~clk;

    avst_host_cmd_mux #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_cmd_data(in_cmd_data), .in_cmd_valid(in_cmd_valid), .in_cmd_ready(in_cmd_ready),
        .out_cmd_data(out_cmd_data), .out_cmd_valid(out_cmd_valid), .out_cmd_ready(out_cmd_ready),
        .in_rsp_data(in_rsp_data), .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready),
        .out_rsp_data(out_rsp_data), .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready),
        .outstanding(outstanding), .err_orphan_rsp(err_orphan_rsp), .grant_count(grant_count)
    );

    task automatic set_ch(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_cmd_data[c*CW +: CW] = {wr, a, d};
    endtask

    task automatic drive_idle();
        in_cmd_valid  = '0;
        in_cmd_data   = '0;
        out_cmd_ready = 1'b1;
        in_rsp_valid  = 1'b0;
        in_rsp_data   = '0;
        out_rsp_ready = '1;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_tags.delete();
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_err       = 1'b0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    // Expected combinational behaviour from the current inputs and model state.
    task automatic predict();
        logic [CW-1:0] cmd;
        bit found;
        found = 0;
        e_g = 0;
        e_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            cmd = in_cmd_data[c*CW +: CW];
            if (!found && in_cmd_valid[c] && (cmd[CW-1] || m_tags.size() < MAXO)) begin
                found = 1;
                e_g = c;
            end
        end
        e_load = found && (!m_out_valid || out_cmd_ready);
        if (e_load) e_ready[e_g] = 1'b1;
        e_rsp_valid = '0;
        if (m_tags.size() == 0) begin
            e_rsp_ready = in_rsp_valid;
            e_orphan    = in_rsp_valid;
            e_pop       = 1'b0;
        end else begin
            if (in_rsp_valid) e_rsp_valid[m_tags[0]] = 1'b1;
            e_rsp_ready = out_rsp_ready[m_tags[0]];
            e_pop       = in_rsp_valid && e_rsp_ready;
            e_orphan    = 1'b0;
        end
    endtask

    task automatic advance();
        if (e_load) begin
            m_out_valid = 1'b1;
            m_out_data  = in_cmd_data[e_g*CW +: CW];
            m_ptr       = (e_g + 1) % NCH;
            m_cnt[e_g]++;
        end else if (out_cmd_ready) begin
            m_out_valid = 1'b0;
        end
        if (e_pop) void'(m_tags.pop_front());
        if (e_load && !m_out_data[CW-1]) m_tags.push_back(e_g);
        if (e_orphan) m_err = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        #12;
        n_vec++;
        if ({in_cmd_ready, out_cmd_data, out_cmd_valid, in_rsp_ready, out_rsp_data, out_rsp_valid,
             outstanding, err_orphan_rsp, grant_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got cmd_valid=%b ready=%b outst=%0d err=%b exp all 0",
                     out_cmd_valid, in_cmd_ready, outstanding, err_orphan_rsp);
        end
        @(negedge clk); reset_n = 1'b1;
        predict(); @(posedge clk); advance(); #1;
    endtask

    task automatic test_single();
        logic [AW-1:0] addrs [3];
        addrs = '{16'h1000, 16'h1040, 16'h1080};
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            if (c < 3) begin in_cmd_valid[0] = 1'b1; set_ch(0, 1'b0, addrs[c], '0); end
            @(negedge clk); predict();
            n_vec++;
            if (in_cmd_ready !== e_ready) begin n_err++;
                $display("FAIL single_ready c=%0d got=%b exp=%b", c, in_cmd_ready, e_ready); end
            n_vec++;
            if (c > 0 && (out_cmd_valid !== 1'b1 || out_cmd_data[DW +: AW] !== addrs[c-1])) begin n_err++;
                $display("FAIL single_cmd c=%0d got v=%b a=%h exp v=1 a=%h", c, out_cmd_valid, out_cmd_data[DW +: AW], addrs[c-1]); end
            @(posedge clk); advance(); #1;
        end
        for (int r = 0; r < 3; r++) begin
            drive_idle();
            in_rsp_valid = 1'b1;
            in_rsp_data  = 32'hD0 + DW'(r);
            @(negedge clk); predict();
            n_vec++;
            if (outstanding !== 3'(3 - r) || out_rsp_valid !== 4'b0001 || out_rsp_data !== in_rsp_data) begin n_err++;
                $display("FAIL single_rsp r=%0d got outst=%0d v=%b d=%h exp outst=%0d v=0001 d=%h",
                         r, outstanding, out_rsp_valid, out_rsp_data, 3 - r, in_rsp_data); end
            @(posedge clk); advance(); #1;
        end
        drive_idle();
        @(negedge clk); predict();
        n_vec++;
        if (outstanding !== 3'd0) begin n_err++;
            $display("FAIL single_drain got=%0d exp=0", outstanding); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_rr_fairness();
        int pulses [NCH];
        for (int i = 0; i < NCH; i++) pulses[i] = 0;
        for (int c = 0; c < 12; c++) begin
            drive_idle();
            in_cmd_valid = '1;
            for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, AW'($urandom), DW'($urandom));
            @(negedge clk); predict();
            for (int i = 0; i < NCH; i++) if (in_cmd_ready[i]) pulses[i]++;
            n_vec++;
            if (in_cmd_ready !== e_ready || out_cmd_data !== m_out_data) begin n_err++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, in_cmd_ready, e_ready); end
            @(posedge clk); advance(); #1;
        end
        for (int i = 0; i < NCH; i++) begin
            n_vec++;
            if (pulses[i] != 3) begin n_err++;
                $display("FAIL rr_pulses ch=%0d got=%0d exp=3", i, pulses[i]); end
        end
    endtask

    task automatic test_interleave();
        int order [3];
        logic [NCH-1:0] route [3];
        order = '{2, 0, 2};
        route = '{4'b0100, 4'b0001, 4'b0100};
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            in_cmd_valid[order[c]] = 1'b1;
            set_ch(order[c], 1'b0, AW'($urandom), '0);
            @(negedge clk); predict();
            @(posedge clk); advance(); #1;
        end
        for (int r = 0; r < 3; r++) begin
            drive_idle();
            in_rsp_valid = 1'b1;
            in_rsp_data  = DW'($urandom);
            @(negedge clk); predict();
            n_vec++;
            if (out_rsp_valid !== route[r] || out_rsp_valid !== e_rsp_valid || in_rsp_ready !== 1'b1) begin n_err++;
                $display("FAIL interleave_route r=%0d got=%b exp=%b rdy=%b", r, out_rsp_valid, route[r], in_rsp_ready); end
            @(posedge clk); advance(); #1;
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            out_cmd_ready = (c >= 6);
            in_cmd_valid  = 4'b1010;
            set_ch(1, 1'b1, 16'h0111, 32'h11111111);
            set_ch(3, 1'b1, 16'h0333, 32'h33333333);
            @(negedge clk); predict();
            n_vec++;
            if (in_cmd_ready !== e_ready || out_cmd_valid !== m_out_valid || out_cmd_data !== m_out_data) begin n_err++;
                $display("FAIL bp_hold c=%0d got rdy=%b v=%b d=%h exp rdy=%b v=%b d=%h",
                         c, in_cmd_ready, out_cmd_valid, out_cmd_data, e_ready, m_out_valid, m_out_data); end
            @(posedge clk); advance(); #1;
        end
        drive_idle();
        in_cmd_valid[2] = 1'b1;
        set_ch(2, 1'b0, 16'h0222, '0);
        @(negedge clk); predict(); @(posedge clk); advance(); #1;
        for (int c = 0; c < 3; c++) begin
            drive_idle();
            in_rsp_valid  = 1'b1;
            out_rsp_ready = (c == 2) ? 4'b0100 : 4'b1011;
            @(negedge clk); predict();
            n_vec++;
            if (in_rsp_ready !== e_rsp_ready || out_rsp_valid !== e_rsp_valid) begin n_err++;
                $display("FAIL bp_rsp c=%0d got rdy=%b v=%b exp rdy=%b v=%b",
                         c, in_rsp_ready, out_rsp_valid, e_rsp_ready, e_rsp_valid); end
            @(posedge clk); advance(); #1;
        end
    endtask

    task automatic test_fifo_full();
        for (int c = 0; c < 12; c++) begin
            drive_idle();
            if (c < 4) begin
                in_cmd_valid[0] = 1'b1;
                set_ch(0, 1'b0, AW'(16'h2000 + c * 64), '0);
            end else begin
                in_cmd_valid[1] = (m_cnt[1] == 0) || (c < 8);
                in_cmd_valid[3] = (c == 4);
                set_ch(1, 1'b0, 16'h0101, '0);
                set_ch(3, 1'b1, 16'h0303, 32'hCAFE0003);
                in_rsp_valid = (c == 6) || (c >= 9);
            end
            @(negedge clk); predict();
            n_vec++;
            if (in_cmd_ready !== e_ready || outstanding !== 3'(m_tags.size())) begin n_err++;
                $display("FAIL full_stall c=%0d got rdy=%b outst=%0d exp rdy=%b outst=%0d",
                         c, in_cmd_ready, outstanding, e_ready, m_tags.size()); end
            @(posedge clk); advance(); #1;
        end
    endtask

    task automatic test_orphan();
        drive_idle();
        while (m_tags.size() != 0) begin
            in_rsp_valid = 1'b1;
            @(negedge clk); predict(); @(posedge clk); advance(); #1;
        end
        in_rsp_valid = 1'b1;
        @(negedge clk); predict();
        n_vec++;
        if (in_rsp_ready !== 1'b1 || out_rsp_valid !== 4'b0000) begin n_err++;
            $display("FAIL orphan_accept got rdy=%b v=%b exp rdy=1 v=0000", in_rsp_ready, out_rsp_valid); end
        @(posedge clk); advance(); #1;
        drive_idle();
        @(negedge clk); predict();
        n_vec++;
        if (err_orphan_rsp !== 1'b1 || err_orphan_rsp !== m_err) begin n_err++;
            $display("FAIL orphan_flag got=%b exp=1", err_orphan_rsp); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_cmd_valid  = NCH'($urandom);
            for (int i = 0; i < NCH; i++) set_ch(i, 1'($urandom), AW'($urandom), DW'($urandom));
            out_cmd_ready = ($urandom_range(0, 3) != 0);
            in_rsp_valid  = ($urandom_range(0, 9) < 4);
            in_rsp_data   = DW'($urandom);
            out_rsp_ready = NCH'($urandom) | NCH'($urandom);
            @(negedge clk); predict();
            n_vec++;
            if (in_cmd_ready !== e_ready || out_cmd_valid !== m_out_valid || out_cmd_data !== m_out_data ||
                out_rsp_valid !== e_rsp_valid || in_rsp_ready !== e_rsp_ready ||
                outstanding !== 3'(m_tags.size()) || err_orphan_rsp !== m_err) begin
                n_err++;
                $display("FAIL random c=%0d got rdy=%b v=%b d=%h rv=%b rr=%b o=%0d e=%b exp rdy=%b v=%b d=%h rv=%b rr=%b o=%0d e=%b",
                         c, in_cmd_ready, out_cmd_valid, out_cmd_data, out_rsp_valid, in_rsp_ready, outstanding, err_orphan_rsp,
                         e_ready, m_out_valid, m_out_data, e_rsp_valid, e_rsp_ready, m_tags.size(), m_err);
            end
            @(posedge clk); advance(); #1;
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            in_cmd_valid = '1;
            for (int i = 0; i < NCH; i++) set_ch(i, 1'(i & 1), AW'($urandom), DW'($urandom));
            out_cmd_ready = 1'b1;
            @(negedge clk); predict(); @(posedge clk); advance(); #1;
        end
        in_rsp_valid = 1'b1;
        in_rsp_data  = 32'hFFFF_FFFF;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({in_cmd_ready, out_cmd_data, out_cmd_valid, in_rsp_ready, out_rsp_data, out_rsp_valid,
             outstanding, err_orphan_rsp, grant_count} !== '0) begin
            n_err++;
            $display("FAIL reset_async got rdy=%b v=%b rr=%b rv=%b o=%0d exp all 0",
                     in_cmd_ready, out_cmd_valid, in_rsp_ready, out_rsp_valid, outstanding);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();
        predict(); @(posedge clk); advance(); #1;
        in_rsp_valid = 1'b1;
        @(negedge clk); predict();
        n_vec++;
        if (in_rsp_ready !== 1'b1 || out_rsp_valid !== 4'b0000 || outstanding !== 3'd0) begin n_err++;
            $display("FAIL reset_orphan got rdy=%b v=%b o=%0d exp rdy=1 v=0000 o=0", in_rsp_ready, out_rsp_valid, outstanding); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_stats();
        for (int c = 0; c < 10; c++) begin
            drive_idle();
            in_cmd_valid[1] = 1'b1;
            set_ch(1, 1'b1, AW'($urandom), DW'($urandom));
            @(negedge clk); predict(); @(posedge clk); advance(); #1;
        end
        drive_idle();
        @(negedge clk); predict();
        n_vec++;
`ifdef AVST_HOST_CMD_MUX_STATS_EN
        if (grant_count[63:32] !== 32'(m_cnt[1]) || m_cnt[1] != 10 || grant_count[31:0] !== 32'(m_cnt[0])) begin n_err++;
            $display("FAIL stats_count got ch1=%0d ch0=%0d exp ch1=%0d ch0=%0d",
                     grant_count[63:32], grant_count[31:0], m_cnt[1], m_cnt[0]); end
`else
        if (grant_count !== '0) begin n_err++;
            $display("FAIL stats_tied got=%h exp=0", grant_count); end
`endif
        @(posedge clk); advance(); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_interleave();
        test_backpressure();
        test_fifo_full();
        test_orphan();
        test_random();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avst_host_cmd_mux.md
Name: avst_host_cmd_mux

Overview:
- N-channel merger between multiple DMA engines and the single CCI-P host bridge command/response stream pair (avcmd / rd_rsp).
- Round-robin arbitrates per-channel Avalon-ST command streams onto one registered output.
- Records the issuing channel of every read in an in-order tag FIFO and steers returning read responses back to that channel.
- Sits in the Clk_400 domain between the DMA subsystem and the host bridge; generalises the current one-master arrangement to NUM_CH masters.

Parameters:
- NUM_CH, 4, number of upstream command channels (2..8).
- ADDR_W, 48, host byte-address width.
- DATA_W, 512, data width.
- MAX_OUTSTANDING, 64, maximum reads in flight. Tag FIFO depth; power of 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_cmd_data  in  NUM_CH*CMD_W  per-channel command. CMD_W = DATA_W+ADDR_W+1. Layout per channel: bit [DATA_W+ADDR_W] is write flag; [DATA_W+ADDR_W-1:DATA_W] is address; [DATA_W-1:0] is write data.
- in_cmd_valid  in  NUM_CH  per-channel command valid.
- in_cmd_ready  out  NUM_CH  per-channel command accept.
- out_cmd_data  out  CMD_W  merged command to host bridge.
- out_cmd_valid  out  1  merged command valid.
- out_cmd_ready  in  1  host bridge accept.
- in_rsp_data  in  DATA_W  read response from host bridge, in request order.
- in_rsp_valid  in  1  response valid.
- in_rsp_ready  out  1  response accept.
- out_rsp_data  out  DATA_W  response data, broadcast to all channels.
- out_rsp_valid  out  NUM_CH  one-hot response valid.
- out_rsp_ready  in  NUM_CH  per-channel response accept.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight.
- err_orphan_rsp  out  1  sticky: response arrived with tag FIFO empty.
- grant_count  out  NUM_CH*32  per-channel accepted-command counters; see Optional Feature.

Behaviour:
- Reset state: all outputs 0. RR pointer = 0, tag FIFO empty, error flag clear, counters 0.
- Eligibility: channel i is eligible when in_cmd_valid[i] is set and it is NOT a read while the FIFO is full (outstanding == MAX_OUTSTANDING). Writes are never blocked by FIFO state.
- Output register:
  - Loads when (!out_cmd_valid || out_cmd_ready) and at least one channel is eligible.
  - Grant goes to the first eligible channel at or after the RR pointer, searching upward and wrapping.
  - in_cmd_ready is one-hot on the granted channel only, and only in the load cycle.
  - Latency: accepted on edge k, presented at out_cmd_valid from cycle k+1.
  - Full throughput: 1 command per cycle while out_cmd_ready stays high.
- RR pointer: on each grant, set to (granted+1) mod NUM_CH. Unchanged when there is no grant.
- Holding: out_cmd_valid and out_cmd_data stay stable until out_cmd_ready is seen.
- Tag push: a granted read pushes its channel index into the tag FIFO in the load cycle. Writes push nothing.
- Response routing:
  - When the FIFO is not empty, out_rsp_valid[head] = in_rsp_valid and in_rsp_ready = out_rsp_ready[head].
  - The FIFO pops on in_rsp_valid && in_rsp_ready.
  - Response path is combinational, zero latency.
- Orphan response: in_rsp_valid with FIFO empty gives in_rsp_ready=1 and the response is dropped. err_orphan_rsp is set and stays set until reset.
- Simultaneous push and pop: outstanding is unchanged. A push while full cannot occur because eligibility blocks it.
- Reset mid-operation: the asynchronous assert clears the output register, FIFO, pointer and flag immediately. Any response after reset counts as an orphan.

Optional Feature:
- Macro: AVST_HOST_CMD_MUX_STATS_EN.
- Defined: grant_count[i*32+:32] increments on each grant to channel i and wraps at 2^32. Reset to 0.
- Undefined: grant_count is tied to 0 and no counter flops are inferred.

Decomposition:
- Package avst_host_mux_pkg holds:
  - function cmd_w(addr_w, data_w);
  - localparam bit offsets CMD_WR_BIT and CMD_ADDR_LSB (relative, as functions of DATA_W/ADDR_W);
  - typedef t_ch_idx sized for 8 channels.
- Sub-module avst_tag_fifo: synchronous-read-free register FIFO of t_ch_idx, depth MAX_OUTSTANDING. Ports push/pop/full/empty/count/head.

Test Plan:
- Single channel: ch0 issues reads at 0x1000, 0x1040, 0x1080 with out_cmd_ready=1 -> out_cmd_valid on cycles 1,2,3 with those addresses. Three responses return D0..D2 only on out_rsp_valid[0]; outstanding goes 3 -> 0.
- RR fairness: all 4 channels valid continuously with writes -> grant order 0,1,2,3,0,1,... and each in_cmd_ready pulses exactly every 4th cycle.
- Interleaved routing: ch2 read, ch0 read, ch2 read, then responses A,B,C -> A to ch2, B to ch0, C to ch2.
- Backpressure: out_cmd_ready low for 5 cycles -> out_cmd_data stable, no further in_cmd_ready. out_rsp_ready[head]=0 -> in_rsp_ready=0.
- FIFO full with MAX_OUTSTANDING=4: 4 reads outstanding, ch1 read plus ch3 write pending -> ch3 write granted, ch1 stalled. One response pops the FIFO -> ch1 granted the next cycle.
- Orphan and reset: in_rsp_valid with empty FIFO -> in_rsp_ready=1 and err_orphan_rsp=1. Asserting reset_n=0 mid-burst -> all outputs 0 asynchronously. With STATS_EN, 10 grants to ch1 -> grant_count[63:32]=10.
